oob_supervisor_dev: RTL and testbench
=====================================

# oob_supervisor_dev

Parametrised device-side OOB supervisor that replaces the fixed start/restart glue around the `oob_dev` engine. It does the following:
- sequences OOB start requests;
- retries failed attempts with bounded exponential backoff;
- debounces loss of byte alignment;
- reports sticky failure and saturating link statistics.

It sits between the GTX reset/ready logic and `oob_dev`, and drives `phy_ready` to the link layer.

## Interface
Parameters:
- `CLK_SPEED_GRADE`, 2 — 1: 75 MHz, 2: 150 MHz, 4: 300 MHz; scales `BACKOFF_BASE` and `ALIGN_LOSS_CYCLES` by this factor.
- `MAX_RETRIES`, 3 — failed attempts tolerated before `link_fail`.
- `BACKOFF_BASE`, 256 — backoff length unit, in cycles at grade 1.
- `BACKOFF_MAX_SHIFT`, 4 — cap on the exponent.
- `ALIGN_LOSS_CYCLES`, 8 — consecutive misaligned cycles (grade 1) that count as a link loss.
- `CNT_W`, 8 — width of the statistics counters.

Ports (one clock; reset is synchronous, active-high):
- `clk` in 1 — sata clk = usrclk2.
- `rst` in 1 — synchronous, active-high.
- `gtx_ready` in 1 — all GTX resets done.
- `rxbyteisaligned` in 1 — async to logic; resynchronised internally with 2 flops.
- `oob_busy`, `oob_done`, `link_up`, `link_down`, `oob_error`, `oob_silence`, `cominit_req` in 1 each — from `oob_dev`.
- `retry_clear` in 1 — pulse; leaves FAIL.
- `oob_start` out 1 — to `oob_dev`.
- `cominit_allow` out 1 — to `oob_dev`.
- `txelecidle_force` out 1 — ORed with the engine's `txelecidle`.
- `phy_ready` out 1 — link usable.
- `link_fail` out 1 — sticky; retries exhausted.
- `retry_cnt` out `$clog2(MAX_RETRIES+1)` — failed attempts in the current series.
- `link_drop_cnt` out `CNT_W` — saturating count of LINK exits.
- `state` out 3 — current FSM state, for debug.

## Operation
States: IDLE, START, WAIT, LINK, BACKOFF, FAIL.

- **IDLE**
  - `gtx_ready & ~oob_busy` → START.
  - `txelecidle_force`=1.
- **START**
  - `oob_start`=1 for exactly this one cycle, then → WAIT.
- **WAIT**
  - `oob_error | oob_silence` → retry handling (this takes priority over `oob_done` in the same cycle):
    - if `retry_cnt`==`MAX_RETRIES` → FAIL;
    - otherwise `retry_cnt`++, load backoff = `BACKOFF_BASE*CLK_SPEED_GRADE` << min(new `retry_cnt`, `BACKOFF_MAX_SHIFT`), → BACKOFF.
  - Else `oob_done & link_up` → LINK, and `retry_cnt` clears to 0.
- **LINK**
  - `phy_ready` = `gtx_ready & aligned_rr`.
  - `cominit_allow` = `cominit_req` (combinational, LINK only); when asserted → WAIT with no backoff and no drop count.
  - `link_down`, or `aligned_rr` low for `ALIGN_LOSS_CYCLES*CLK_SPEED_GRADE` consecutive cycles → BACKOFF:
    - backoff loaded with `BACKOFF_BASE*CLK_SPEED_GRADE`;
    - `link_drop_cnt`++, saturating at 2^`CNT_W`−1.
  - The misalignment counter resets on any aligned cycle.
- **BACKOFF**
  - `txelecidle_force`=1.
  - Counter decrements each cycle; at 0 → IDLE.
- **FAIL**
  - `link_fail`=1, `txelecidle_force`=1.
  - Leaves only on `rst`, or on `retry_clear` → IDLE with `retry_cnt` cleared.
- **Global**
  - `gtx_ready` low in START/WAIT/LINK/BACKOFF → IDLE next cycle; counters are kept.
  - Priority: `rst` > `gtx_ready` drop > `cominit_req` > `link_down`/alignment loss.

## Timing
- **Reset:** state=IDLE; `retry_cnt`=0, `link_drop_cnt`=0. Every output is 0 except `txelecidle_force`=1 (IDLE).
- **Start latency:** `oob_start` is high exactly 1 cycle after IDLE samples `gtx_ready & ~oob_busy`.
- **Output registration:**
  - `oob_start`, `link_fail` and `state` are decodes of the state register.
  - `phy_ready` and `cominit_allow` are combinational from the state register plus their listed inputs.
- **Alignment path:** 2-cycle resync on `rxbyteisaligned`, so `phy_ready` falls 2 cycles after `rxbyteisaligned` falls.
- **Backoff duration:** a backoff value L keeps BACKOFF for L+1 cycles (the load cycle plus L decrements).
- **Counters:** `retry_cnt` never exceeds `MAX_RETRIES`. All counters saturate and never wrap.
- **`rst` mid-backoff:** IDLE on the next edge, counter cleared.

## Structure
- Shared header `oob_sup_defs.vh`: state encodings and the `BACKOFF_W` width function, i.e. `$clog2(BACKOFF_BASE*CLK_SPEED_GRADE<<BACKOFF_MAX_SHIFT)+1`.
- Sub-module `oob_backoff_timer`: load value, enable, and `expired` output; it holds the shift/cap arithmetic.
- The 2-flop synchroniser is inline.

## Test plan
Defaults for all cases: `MAX_RETRIES`=3, `BACKOFF_BASE`=16, `BACKOFF_MAX_SHIFT`=2, `CLK_SPEED_GRADE`=1, `ALIGN_LOSS_CYCLES`=8.

- **Clean bring-up:** `gtx_ready`=1, then `oob_done`+`link_up` 50 cycles after `oob_start` → state LINK, `phy_ready`=1 two cycles after `rxbyteisaligned`=1, `retry_cnt`=0.
- **Retry/backoff:** four successive `oob_silence` pulses → backoffs of 33, 65, 65 cycles between `oob_start` pulses; the 4th goes to FAIL, `link_fail`=1. `retry_clear` → IDLE, next `oob_start` 2 cycles later.
- **Alignment debounce:** in LINK, drop alignment for 7 cycles → stays in LINK, `link_drop_cnt`=0. Drop for 8 cycles → BACKOFF, `link_drop_cnt`=1.
- **Simultaneous events:** `oob_error` and `oob_done` in the same WAIT cycle → BACKOFF, `retry_cnt`=1. `cominit_req` and `link_down` together in LINK → `cominit_allow`=1, then WAIT.
- **Interruptions:** `gtx_ready` low mid-BACKOFF → IDLE next cycle. `rst` in LINK → all counters 0, `phy_ready`=0 the next cycle.
- **Saturation:** with `CNT_W`=2, force 5 link drops → `link_drop_cnt`=3.

Source files
------------

// File: rtl/oob_supervisor_dev_pkg.sv
// rtl/oob_supervisor_dev_pkg.sv - shared state encodings and backoff width helper
// for the OOB supervisor slice.
package oob_supervisor_dev_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_LINK    = 3'd3;
  localparam logic [2:0] ST_BACKOFF = 3'd4;
  localparam logic [2:0] ST_FAIL    = 3'd5;

  // One spare bit above the largest shifted backoff so the capped value always fits.
  function automatic int backoff_w(input int base, input int grade, input int max_shift);
    return $clog2((base * grade) << max_shift) + 1;
  endfunction

endpackage

// File: rtl/oob_supervisor_dev_if.sv
// rtl/oob_supervisor_dev_if.sv - handshake bundle between the supervisor (master)
// and the oob_dev engine (slave).
interface oob_supervisor_dev_if;

  logic oob_busy;
  logic oob_done;
  logic link_up;
  logic link_down;
  logic oob_error;
  logic oob_silence;
  logic cominit_req;
  logic oob_start;
  logic cominit_allow;
  logic txelecidle_force;

  modport master (
    input  oob_busy, oob_done, link_up, link_down, oob_error, oob_silence, cominit_req,
    output oob_start, cominit_allow, txelecidle_force
  );

  modport slave (
    output oob_busy, oob_done, link_up, link_down, oob_error, oob_silence, cominit_req,
    input  oob_start, cominit_allow, txelecidle_force
  );

endinterface

// File: rtl/oob_supervisor_dev_backoff_timer.sv
// rtl/oob_supervisor_dev_backoff_timer.sv - loadable down-counter; load value is
// BASE shifted by the requested exponent, capped at MAX_SHIFT.
module oob_backoff_timer
  import oob_supervisor_dev_pkg::*;
#(
  parameter int BASE      = 16,
  parameter int MAX_SHIFT = 2,
  parameter int SHIFT_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [SHIFT_W-1:0] i_shift,
  input  logic               i_en,
  output logic               o_expired
);

  localparam int W = backoff_w(BASE, 1, MAX_SHIFT);
  localparam logic [W-1:0] BASE_V = W'(BASE);

  logic [W-1:0] r_count;
  logic [W-1:0] w_load_val;

  always_comb begin
    if (int'(i_shift) > MAX_SHIFT) w_load_val = BASE_V << MAX_SHIFT;
    else                           w_load_val = BASE_V << i_shift;
  end

  always_ff @(posedge clk) begin
    if (rst)                          r_count <= '0;
    else if (i_load)                  r_count <= w_load_val;
    else if (i_en && r_count != '0)   r_count <= r_count - 1'b1;
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/oob_supervisor_dev.sv
// rtl/oob_supervisor_dev.sv - device-side OOB start/retry supervisor: bounded
// exponential backoff, alignment-loss debounce, sticky fail and link statistics.
module oob_supervisor_dev
  import oob_supervisor_dev_pkg::*;
#(
  parameter int CLK_SPEED_GRADE   = 2,
  parameter int MAX_RETRIES       = 3,
  parameter int BACKOFF_BASE      = 256,
  parameter int BACKOFF_MAX_SHIFT = 4,
  parameter int ALIGN_LOSS_CYCLES = 8,
  parameter int CNT_W             = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             gtx_ready,
  input  logic                             rxbyteisaligned,
  input  logic                             retry_clear,
  oob_supervisor_dev_if.master             oob,
  output logic                             phy_ready,
  output logic                             link_fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt,
  output logic [CNT_W-1:0]                 link_drop_cnt,
  output logic [2:0]                       state
);

  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
  localparam int ALIGN_N = ALIGN_LOSS_CYCLES * CLK_SPEED_GRADE;
  localparam int ALIGN_W = $clog2(ALIGN_N + 1);

  logic [2:0]         r_state;
  logic [RETRY_W-1:0] r_retry_cnt;
  logic [CNT_W-1:0]   r_drop_cnt;
  logic               r_align_r;
  logic               r_align_rr;
  logic [ALIGN_W-1:0] r_misalign;

  logic [2:0]         w_next_state;
  logic               w_bo_load;
  logic [RETRY_W-1:0] w_bo_shift;
  logic               w_bo_expired;
  logic               w_retry_inc;
  logic               w_retry_clr;
  logic               w_drop_inc;
  logic               w_align_loss;

  assign w_align_loss = (r_state == ST_LINK) && !r_align_rr &&
                        (r_misalign == ALIGN_W'(ALIGN_N - 1));

  always_comb begin
    w_next_state = r_state;
    w_bo_load    = 1'b0;
    w_bo_shift   = '0;
    w_retry_inc  = 1'b0;
    w_retry_clr  = 1'b0;
    w_drop_inc   = 1'b0;
    case (r_state)
      ST_IDLE: if (gtx_ready && !oob.oob_busy) w_next_state = ST_START;
      ST_START: w_next_state = gtx_ready ? ST_WAIT : ST_IDLE;
      ST_WAIT: begin
        if (!gtx_ready) begin
          w_next_state = ST_IDLE;
        end else if (oob.oob_error || oob.oob_silence) begin
          // A failure report wins over a same-cycle done.
          if (r_retry_cnt == RETRY_W'(MAX_RETRIES)) begin
            w_next_state = ST_FAIL;
          end else begin
            w_retry_inc  = 1'b1;
            w_bo_load    = 1'b1;
            w_bo_shift   = r_retry_cnt + 1'b1;
            w_next_state = ST_BACKOFF;
          end
        end else if (oob.oob_done && oob.link_up) begin
          w_retry_clr  = 1'b1;
          w_next_state = ST_LINK;
        end
      end
      ST_LINK: begin
        if (!gtx_ready) begin
          w_next_state = ST_IDLE;
        end else if (oob.cominit_req) begin
          w_next_state = ST_WAIT;
        end else if (oob.link_down || w_align_loss) begin
          w_bo_load    = 1'b1;
          w_drop_inc   = 1'b1;
          w_next_state = ST_BACKOFF;
        end
      end
      ST_BACKOFF: if (!gtx_ready || w_bo_expired) w_next_state = ST_IDLE;
      ST_FAIL: begin
        if (retry_clear) begin
          w_retry_clr  = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_retry_cnt <= '0;
      r_drop_cnt  <= '0;
      r_align_r   <= 1'b0;
      r_align_rr  <= 1'b0;
      r_misalign  <= '0;
    end else begin
      r_state    <= w_next_state;
      r_align_r  <= rxbyteisaligned;
      r_align_rr <= r_align_r;
      if (w_retry_clr)      r_retry_cnt <= '0;
      else if (w_retry_inc) r_retry_cnt <= r_retry_cnt + 1'b1;
      if (w_drop_inc && r_drop_cnt != {CNT_W{1'b1}}) r_drop_cnt <= r_drop_cnt + 1'b1;
      if (r_state != ST_LINK || r_align_rr) r_misalign <= '0;
      else if (!w_align_loss)               r_misalign <= r_misalign + 1'b1;
    end
  end

  oob_backoff_timer #(
    .BASE      (BACKOFF_BASE * CLK_SPEED_GRADE),
    .MAX_SHIFT (BACKOFF_MAX_SHIFT),
    .SHIFT_W   (RETRY_W)
  ) u_backoff (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_bo_load),
    .i_shift   (w_bo_shift),
    .i_en      (r_state == ST_BACKOFF),
    .o_expired (w_bo_expired)
  );

  assign oob.oob_start        = (r_state == ST_START);
  assign oob.txelecidle_force = (r_state == ST_IDLE) || (r_state == ST_BACKOFF) ||
                                (r_state == ST_FAIL);
  assign oob.cominit_allow    = (r_state == ST_LINK) && oob.cominit_req;
  assign phy_ready            = (r_state == ST_LINK) && gtx_ready && r_align_rr;
  assign link_fail            = (r_state == ST_FAIL);
  assign retry_cnt            = r_retry_cnt;
  assign link_drop_cnt        = r_drop_cnt;
  assign state                = r_state;

endmodule

// File: tb/tb_oob_supervisor_dev.sv
// tb/tb_oob_supervisor_dev.sv - directed self-checking bench for oob_supervisor_dev.
module tb_oob_supervisor_dev;

  logic       clk = 1'b0;
  logic       rst;
  logic       gtx_ready;
  logic       rxbyteisaligned;
  logic       retry_clear;
  logic       phy_ready;
  logic       link_fail;
  logic [1:0] retry_cnt;
  logic [1:0] link_drop_cnt;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  oob_supervisor_dev_if ifc();

  oob_supervisor_dev #(
    .CLK_SPEED_GRADE   (1),
    .MAX_RETRIES       (3),
    .BACKOFF_BASE      (16),
    .BACKOFF_MAX_SHIFT (2),
    .ALIGN_LOSS_CYCLES (8),
    .CNT_W             (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .gtx_ready       (gtx_ready),
    .rxbyteisaligned (rxbyteisaligned),
    .retry_clear     (retry_clear),
    .oob             (ifc),
    .phy_ready       (phy_ready),
    .link_fail       (link_fail),
    .retry_cnt       (retry_cnt),
    .link_drop_cnt   (link_drop_cnt),
    .state           (state)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; gtx_ready = 1'b0; rxbyteisaligned = 1'b0; retry_clear = 1'b0;
    ifc.oob_busy = 1'b0; ifc.oob_done = 1'b0; ifc.link_up = 1'b0; ifc.link_down = 1'b0;
    ifc.oob_error = 1'b0; ifc.oob_silence = 1'b0; ifc.cominit_req = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    int n;
    n = 0;
    while (ifc.oob_start !== 1'b1 && n < 300) begin
      tick(1);
      n++;
    end
    ok = (ifc.oob_start === 1'b1);
  endtask

  task automatic bring_up(output bit ok);
    gtx_ready = 1'b1;
    rxbyteisaligned = 1'b1;
    wait_start(ok);
    tick(1);
    ifc.oob_done = 1'b1; ifc.link_up = 1'b1;
    tick(1);
    ifc.oob_done = 1'b0; ifc.link_up = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (retry_cnt !== 2'd0) begin errors++; $display("FAIL reset_retry: got %0d expected 0", retry_cnt); end
    checks++; if (link_drop_cnt !== 2'd0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", link_drop_cnt); end
    checks++; if (ifc.txelecidle_force !== 1'b1) begin errors++; $display("FAIL reset_elecidle: got %0b expected 1", ifc.txelecidle_force); end
    checks++; if ({ifc.oob_start, ifc.cominit_allow, phy_ready, link_fail} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs: got %b expected 0000", {ifc.oob_start, ifc.cominit_allow, phy_ready, link_fail});
    end
  endtask

  task automatic test_bringup();
    do_reset();
    gtx_ready = 1'b1;
    tick(1);
    checks++; if (ifc.oob_start !== 1'b1) begin errors++; $display("FAIL bringup_start_latency: got %0b expected 1", ifc.oob_start); end
    tick(1);
    checks++; if (ifc.oob_start !== 1'b0 || state !== 3'd2) begin
      errors++; $display("FAIL bringup_start_pulse: got start=%0b state=%0d expected start=0 state=2", ifc.oob_start, state);
    end
    tick(49);
    ifc.oob_done = 1'b1; ifc.link_up = 1'b1;
    tick(1);
    ifc.oob_done = 1'b0;
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL bringup_link: got %0d expected 3", state); end
    checks++; if (retry_cnt !== 2'd0) begin errors++; $display("FAIL bringup_retry: got %0d expected 0", retry_cnt); end
    checks++; if (phy_ready !== 1'b0) begin errors++; $display("FAIL bringup_phy_unaligned: got %0b expected 0", phy_ready); end
    rxbyteisaligned = 1'b1;
    tick(1);
    checks++; if (phy_ready !== 1'b0) begin errors++; $display("FAIL bringup_phy_1cyc: got %0b expected 0", phy_ready); end
    tick(1);
    checks++; if (phy_ready !== 1'b1) begin errors++; $display("FAIL bringup_phy_2cyc: got %0b expected 1", phy_ready); end
    ifc.link_up = 1'b0;
  endtask

  task automatic test_retry_backoff();
    int n;
    bit ok;
    int exp_bo[3];
    exp_bo = '{33, 65, 65};
    do_reset();
    gtx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_start(ok);
      checks++; if (!ok) begin errors++; $display("FAIL retry_start_%0d: got timeout expected oob_start", i); end
      tick(1);
      ifc.oob_silence = 1'b1;
      tick(1);
      ifc.oob_silence = 1'b0;
      if (i < 3) begin
        checks++; if (retry_cnt !== 2'(i + 1)) begin errors++; $display("FAIL retry_cnt_%0d: got %0d expected %0d", i, retry_cnt, i + 1); end
        n = 0;
        while (state === 3'd4 && n < 200) begin
          n++;
          tick(1);
        end
        checks++; if (n != exp_bo[i]) begin errors++; $display("FAIL backoff_len_%0d: got %0d expected %0d", i, n, exp_bo[i]); end
      end
    end
    checks++; if (state !== 3'd5 || link_fail !== 1'b1) begin
      errors++; $display("FAIL retry_fail: got state=%0d link_fail=%0b expected state=5 link_fail=1", state, link_fail);
    end
    checks++; if (retry_cnt !== 2'd3) begin errors++; $display("FAIL retry_cnt_max: got %0d expected 3", retry_cnt); end
    tick(3);
    checks++; if (state !== 3'd5 || ifc.txelecidle_force !== 1'b1) begin
      errors++; $display("FAIL fail_sticky: got state=%0d elecidle=%0b expected state=5 elecidle=1", state, ifc.txelecidle_force);
    end
    retry_clear = 1'b1;
    tick(1);
    retry_clear = 1'b0;
    checks++; if (state !== 3'd0 || retry_cnt !== 2'd0) begin
      errors++; $display("FAIL retry_clear: got state=%0d retry=%0d expected state=0 retry=0", state, retry_cnt);
    end
    tick(1);
    checks++; if (ifc.oob_start !== 1'b1) begin errors++; $display("FAIL clear_restart: got %0b expected 1", ifc.oob_start); end
  endtask

  task automatic test_align_debounce();
    bit ok;
    do_reset();
    bring_up(ok);
    checks++; if (!ok || state !== 3'd3) begin errors++; $display("FAIL align_link: got ok=%0b state=%0d expected ok=1 state=3", ok, state); end
    rxbyteisaligned = 1'b0;
    tick(7);
    rxbyteisaligned = 1'b1;
    tick(4);
    checks++; if (state !== 3'd3 || link_drop_cnt !== 2'd0) begin
      errors++; $display("FAIL align_7: got state=%0d drops=%0d expected state=3 drops=0", state, link_drop_cnt);
    end
    rxbyteisaligned = 1'b0;
    tick(1);
    checks++; if (phy_ready !== 1'b1) begin errors++; $display("FAIL align_phy_hold: got %0b expected 1", phy_ready); end
    tick(1);
    checks++; if (phy_ready !== 1'b0) begin errors++; $display("FAIL align_phy_fall: got %0b expected 0", phy_ready); end
    tick(7);
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL align_8_early: got %0d expected 3", state); end
    tick(1);
    checks++; if (state !== 3'd4 || link_drop_cnt !== 2'd1) begin
      errors++; $display("FAIL align_8: got state=%0d drops=%0d expected state=4 drops=1", state, link_drop_cnt);
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    do_reset();
    gtx_ready = 1'b1;
    rxbyteisaligned = 1'b1;
    wait_start(ok);
    tick(1);
    ifc.oob_error = 1'b1; ifc.oob_done = 1'b1; ifc.link_up = 1'b1;
    tick(1);
    ifc.oob_error = 1'b0; ifc.oob_done = 1'b0; ifc.link_up = 1'b0;
    checks++; if (!ok || state !== 3'd4 || retry_cnt !== 2'd1) begin
      errors++; $display("FAIL err_vs_done: got state=%0d retry=%0d expected state=4 retry=1", state, retry_cnt);
    end
    bring_up(ok);
    checks++; if (!ok || state !== 3'd3) begin errors++; $display("FAIL simul_link: got state=%0d expected 3", state); end
    ifc.cominit_req = 1'b1; ifc.link_down = 1'b1;
    #1;
    checks++; if (ifc.cominit_allow !== 1'b1) begin errors++; $display("FAIL cominit_allow: got %0b expected 1", ifc.cominit_allow); end
    tick(1);
    ifc.cominit_req = 1'b0; ifc.link_down = 1'b0;
    checks++; if (state !== 3'd2 || link_drop_cnt !== 2'd0) begin
      errors++; $display("FAIL cominit_vs_down: got state=%0d drops=%0d expected state=2 drops=0", state, link_drop_cnt);
    end
  endtask

  task automatic test_interrupt();
    bit ok;
    do_reset();
    gtx_ready = 1'b1;
    wait_start(ok);
    tick(1);
    ifc.oob_silence = 1'b1;
    tick(1);
    ifc.oob_silence = 1'b0;
    tick(5);
    checks++; if (!ok || state !== 3'd4) begin errors++; $display("FAIL int_backoff: got state=%0d expected 4", state); end
    gtx_ready = 1'b0;
    tick(1);
    checks++; if (state !== 3'd0 || retry_cnt !== 2'd1) begin
      errors++; $display("FAIL gtx_drop: got state=%0d retry=%0d expected state=0 retry=1", state, retry_cnt);
    end
    bring_up(ok);
    ifc.link_down = 1'b1;
    tick(1);
    ifc.link_down = 1'b0;
    bring_up(ok);
    checks++; if (!ok || state !== 3'd3 || link_drop_cnt !== 2'd1 || phy_ready !== 1'b1) begin
      errors++; $display("FAIL int_relink: got state=%0d drops=%0d phy=%0b expected state=3 drops=1 phy=1", state, link_drop_cnt, phy_ready);
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++; if (state !== 3'd0 || retry_cnt !== 2'd0 || link_drop_cnt !== 2'd0 || phy_ready !== 1'b0) begin
      errors++; $display("FAIL rst_in_link: got state=%0d retry=%0d drops=%0d phy=%0b expected all 0", state, retry_cnt, link_drop_cnt, phy_ready);
    end
    bring_up(ok);
    ifc.link_down = 1'b1;
    tick(1);
    ifc.link_down = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++; if (state !== 3'd0 || link_drop_cnt !== 2'd0) begin
      errors++; $display("FAIL rst_in_backoff: got state=%0d drops=%0d expected state=0 drops=0", state, link_drop_cnt);
    end
  endtask

  task automatic test_saturation();
    bit ok;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bring_up(ok);
      ifc.link_down = 1'b1;
      tick(1);
      ifc.link_down = 1'b0;
      if (i == 1) begin
        checks++; if (!ok || link_drop_cnt !== 2'd2) begin errors++; $display("FAIL sat_two: got %0d expected 2", link_drop_cnt); end
      end
    end
    checks++; if (link_drop_cnt !== 2'd3 || state !== 3'd4) begin
      errors++; $display("FAIL sat_five: got drops=%0d state=%0d expected drops=3 state=4", link_drop_cnt, state);
    end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_retry_backoff();
    test_align_debounce();
    test_simultaneous();
    test_interrupt();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
